// File: rtl/mult_result_unload_fifo_if.sv
// mult_result_unload_fifo_if: producer/consumer bundle for the multiplier result unload FIFO
interface mult_result_unload_fifo_if #(
    parameter int W  = 32,
    parameter int AW = 2
);
    logic         load;
    logic [W-1:0] D;
    logic         ready;
    logic [W-1:0] Q;
    logic         valid;
    logic         full;
    logic [AW:0]  count;
    logic         overflow;
    logic         clr_ovf;
    modport master (output load, D, ready, clr_ovf, input Q, valid, full, count, overflow);
    modport slave  (input load, D, ready, clr_ovf, output Q, valid, full, count, overflow);
endinterface

// File: rtl/mult_result_unload_fifo.sv
// mult_result_unload_fifo: first-word-fallthrough buffer for multiplier results with sticky drop flag
module mult_result_unload_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic                          clk,
    input logic                          rst,
    mult_result_unload_fifo_if.slave     bus
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          pop;
    logic          push;
    logic          drop;

    assign bus.valid    = cnt != '0;
    assign bus.full     = cnt == (AW+1)'(DEPTH);
    assign bus.count    = cnt;
    assign bus.Q        = mem[rd_ptr];
    assign bus.overflow = ovf;
    assign pop          = bus.valid & bus.ready;
    assign push         = bus.load & (~bus.full | pop);
    assign drop         = bus.load & bus.full & ~pop;

    // storage, pointers, occupancy and sticky drop flag; a drop outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.D;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
            ovf <= drop ? 1'b1 : bus.clr_ovf ? 1'b0 : ovf;
        end
    end
endmodule

// File: tb/tb_mult_result_unload_fifo.sv
// tb_mult_result_unload_fifo: table-driven plus scoreboard checks of the result unload FIFO
module tb_mult_result_unload_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;
    logic [31:0] sb [$];
    logic m_ovf = 1'b0;

    mult_result_unload_fifo_if #(.W(32), .AW(2)) bus ();
    mult_result_unload_fifo #(.W(32), .DEPTH(4), .AW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [31:0] d;
        logic        ready;
        logic        clr;
        int          cnt;
        logic        valid;
        logic        full;
        logic        ovf;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_state(input string tag, input int c, input logic v, input logic f, input logic o);
        check({tag, " count"}, 32'(bus.count), 32'(c));
        check({tag, " valid"}, 32'(bus.valid), 32'(v));
        check({tag, " full"}, 32'(bus.full), 32'(f));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(o));
    endtask

    // drive one cycle; pops compared against the scoreboard head, pushes queued
    task automatic cycle(input logic ld, input logic [31:0] d, input logic rd, input logic clr);
        bit m_pop;
        bit m_push;
        bus.load = ld; bus.D = d; bus.ready = rd; bus.clr_ovf = clr;
        m_pop  = (sb.size() != 0) && rd;
        m_push = ld && (sb.size() < 4 || m_pop);
        if (m_pop) begin
            check("head", bus.Q, sb[0]);
            void'(sb.pop_front());
        end
        if (ld && !m_push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (m_push) sb.push_back(d);
        @(posedge clk); #1;
        bus.load = 1'b0; bus.ready = 1'b0; bus.clr_ovf = 1'b0;
    endtask

    task automatic model_state(input string tag);
        check_state(tag, sb.size(), sb.size() != 0, sb.size() == 4, m_ovf);
    endtask

    initial begin
        bus.load = 1'b0; bus.D = '0; bus.ready = 1'b0; bus.clr_ovf = 1'b0;
        // single push, then drain
        tbl.push_back('{1, 32'h3F800000, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 32'h0,        1, 0, 0, 0, 0, 0});
        // fill with A..D
        tbl.push_back('{1, 32'hAAAA0001, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{1, 32'hBBBB0002, 0, 0, 2, 1, 0, 0});
        tbl.push_back('{1, 32'hCCCC0003, 0, 0, 3, 1, 0, 0});
        tbl.push_back('{1, 32'hDDDD0004, 0, 0, 4, 1, 1, 0});
        // drop while full, clear, drop beats clear, clear again
        tbl.push_back('{1, 32'hEEEE0005, 0, 0, 4, 1, 1, 1});
        tbl.push_back('{0, 32'h0,        0, 1, 4, 1, 1, 0});
        tbl.push_back('{1, 32'h99990009, 0, 1, 4, 1, 1, 1});
        tbl.push_back('{0, 32'h0,        0, 1, 4, 1, 1, 0});
        // push and pop while full: no drop, new word drained last
        tbl.push_back('{1, 32'hFFFF0006, 1, 0, 4, 1, 1, 0});
        tbl.push_back('{0, 32'h0,        1, 0, 3, 1, 0, 0});
        tbl.push_back('{0, 32'h0,        1, 0, 2, 1, 0, 0});
        tbl.push_back('{0, 32'h0,        1, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 32'h0,        1, 0, 0, 0, 0, 0});
        // ready while empty is ignored
        tbl.push_back('{0, 32'h0,        1, 0, 0, 0, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_state("reset");
        check("reset Q", bus.Q, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].load, tbl[i].d, tbl[i].ready, tbl[i].clr);
            check_state($sformatf("row%0d", i), tbl[i].cnt, tbl[i].valid, tbl[i].full, tbl[i].ovf);
            if (i == 0) check("first word Q", bus.Q, 32'h3F800000);
        end
        check("sb drained", 32'(sb.size()), 32'd0);

        // continuous push and pop from count 1: pointers wrap, order preserved
        cycle(1'b1, 32'h10000000, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 32'h10000000 + 32'(i), 1'b1, 1'b0);
            check($sformatf("stream%0d count", i), 32'(bus.count), 32'd1);
            check($sformatf("stream%0d Q", i), bus.Q, 32'h10000000 + 32'(i));
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        model_state("stream end");

        // reset with three words stored
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h20000000 + 32'(i), 1'b0, 1'b0);
        model_state("pre-reset");
        check("pre-reset count", 32'(bus.count), 32'd3);
        rst = 1'b0;
        bus.load = 1'b1; bus.D = 32'hDEADBEEF;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.load = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        check_state("mid reset", 0, 1'b0, 1'b0, 1'b0);
        check("mid reset Q", bus.Q, 32'h0);
        cycle(1'b1, 32'h30000001, 1'b0, 1'b0);
        check("new head Q", bus.Q, 32'h30000001);
        model_state("post-reset push");
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        model_state("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
